modulo_counter_ctrl: RTL and testbench
======================================

# modulo_counter_ctrl

Command-driven controller for a programmable modulo-k up-counter. Accepts LOAD/START/STOP/CLEAR commands over a valid/ready handshake and owns the modulus register. Advances the count on external tick pulses and counts completed wraps against a programmed repeat count, signalling completion with a one-cycle done pulse. Sits between the pushbutton/command front end and the display/LED datapath.

## Interface
- N, 8: counter, modulus and repeat-count width.
- K, 10: modulus after reset; must be in the range 0 to 2^N-1 (0 means 2^N).
- clock  in  1  rising-edge system clock.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_op  in  2  00 START, 01 STOP, 10 CLEAR, 11 LOAD.
- cmd_data  in  N  LOAD: new modulus. START from IDLE: repeat count R. Ignored otherwise.
- cmd_ready  out  1  controller can accept a command; combinational from state.
- tick  in  1  count-enable pulse, one cycle wide.
- count  out  N  current count, registered.
- modulus  out  N  current modulus register.
- wrap  out  1  registered pulse: count wrapped to 0 on the previous edge.
- done  out  1  registered pulse: final programmed wrap completed.
- busy  out  1  state is RUN or HOLD.
- cmd_err  out  1  registered pulse: an accepted command was illegal in the current state.

## Operation
- A command is accepted when cmd_valid and cmd_ready are both high at the clock edge. cmd_ready = (state != DONE).
- Count step: next = (count == modulus-1) ? 0 : count+1. modulus-1 is computed in N bits, so modulus 0 gives full 2^N range and modulus 1 holds count at 0 with a wrap on every tick.
- Internal wraps_left register is N bits wide. R = 0 means run indefinitely, with no decrement and no done.
- States:
  - IDLE: tick ignored.
    - START: load wraps_left = cmd_data and go to RUN. count is not cleared.
    - LOAD: modulus = cmd_data, count = 0.
    - CLEAR: count = 0.
    - STOP: no effect, no error.
  - RUN: tick advances count.
    - On a wrap: pulse wrap. If wraps_left == 1, go to DONE. If wraps_left > 1, decrement it.
    - STOP: go to HOLD.
    - CLEAR: count = 0 and stay in RUN; wraps_left is unchanged.
    - START: no effect.
    - LOAD: cmd_err pulse; modulus is unchanged.
  - HOLD: tick ignored.
    - START: return to RUN; cmd_data ignored and wraps_left kept.
    - CLEAR: count = 0, wraps_left = 0, go to IDLE.
    - STOP: no effect.
    - LOAD: cmd_err pulse.
  - DONE: lasts exactly one cycle and goes unconditionally to IDLE.
    - done = 1, count = 0, cmd_ready = 0.
    - tick is ignored; cmd_valid is not accepted, and the command must be held by its source.
- Simultaneous command and tick in RUN: the command has priority.
  - STOP or CLEAR: the tick is discarded, with no advance and no wrap.
  - START or LOAD: the tick is processed normally; LOAD still pulses cmd_err.
- Reset at any point: state IDLE, count 0, modulus K, wraps_left 0; wrap, done and cmd_err all 0. Any in-flight command is dropped.

## Timing
- Tick to count update: 1 cycle. The tick sampled at edge t is visible on count after edge t.
- wrap is high for the single cycle in which count first reads 0 after a wrap.
- On the final wrap, done and wrap are high in the same cycle, state is DONE, and cmd_ready is low. IDLE follows on the next cycle.
- Command to effect: 1 cycle. cmd_err is high the cycle after the illegal command is accepted.
- busy reflects the registered state; there is no combinational path from cmd_* to busy.
- No combinational path from any input to any output.

## Test plan
- Reset, then LOAD 5 and START R=2, with tick every cycle.
  - Expect count 1,2,3,4,0,1,2,3,4,0.
  - wrap on each 0. done coincides with the second 0, and cmd_ready is low that cycle.
  - Next cycle: IDLE, busy = 0.
- Modulus edge cases.
  - LOAD 0 with N=8, START R=1: count runs 0 to 255, then wraps to 0 with done on 256 ticks.
  - LOAD 1, START R=3: done on the third tick; count stays at 0 throughout.
- Pause and clear.
  - START R=0, tick to count 3, STOP with tick asserted: count holds at 3, busy stays 1.
  - START: counting resumes from 3.
  - STOP, then CLEAR: IDLE, count 0.
- Illegal and priority.
  - LOAD 7 in RUN: cmd_err pulses once and modulus stays 10.
  - CLEAR with tick at count 9: count becomes 0 and wrap does not pulse.
- Mid-run reset.
  - reset asserted for one cycle at count 6 in RUN, R=4: next cycle count 0, modulus 10, IDLE.
  - Then drive 20 ticks: count holds at 0 and no wrap or done pulses.
- DONE backpressure.
  - cmd_valid held high with START R=1 across the DONE cycle: not accepted in DONE.
  - Accepted the following cycle from IDLE, and RUN resumes.

Source files
------------

// File: rtl/modulo_counter_ctrl_if.sv
// rtl/modulo_counter_ctrl_if.sv - command handshake bundle for the modulo counter controller
interface modulo_counter_ctrl_if #(
  parameter int N = 8
);
  logic         cmd_valid;
  logic [1:0]   cmd_op;
  logic [N-1:0] cmd_data;
  logic         cmd_ready;

  modport master (output cmd_valid, cmd_op, cmd_data, input cmd_ready);
  modport slave  (input cmd_valid, cmd_op, cmd_data, output cmd_ready);
endinterface

// File: rtl/modulo_counter_ctrl.sv
// rtl/modulo_counter_ctrl.sv - command-driven modulo-k up-counter with repeat-count completion
module modulo_counter_ctrl #(
  parameter int N = 8,
  parameter int K = 10
) (
  input  logic                 clock,
  input  logic                 reset,
  modulo_counter_ctrl_if.slave cmd,
  input  logic                 tick,
  output logic [N-1:0]         count,
  output logic [N-1:0]         modulus,
  output logic                 wrap,
  output logic                 done,
  output logic                 busy,
  output logic                 cmd_err
);

  typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} state_t;

  localparam logic [1:0] OP_START = 2'b00;
  localparam logic [1:0] OP_STOP  = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;
  localparam logic [1:0] OP_LOAD  = 2'b11;

  state_t       state, state_nxt;
  logic [N-1:0] wraps_left, wraps_left_nxt;
  logic [N-1:0] count_nxt, modulus_nxt, last_val;
  logic         wrap_nxt, done_nxt, cmd_err_nxt;
  logic         accept, advance, at_top;

  assign cmd.cmd_ready = (state != DONE);
  assign busy          = (state == RUN) || (state == HOLD);
  assign accept        = cmd.cmd_valid && (state != DONE);
  // modulus 0 wraps last_val to all-ones, giving the full 2^N range
  assign last_val      = modulus - N'(1);
  assign at_top        = (count == last_val);

  always_comb begin
    state_nxt      = state;
    count_nxt      = count;
    modulus_nxt    = modulus;
    wraps_left_nxt = wraps_left;
    wrap_nxt       = 1'b0;
    done_nxt       = 1'b0;
    cmd_err_nxt    = 1'b0;
    advance        = 1'b0;

    case (state)
      IDLE: begin
        if (accept) begin
          case (cmd.cmd_op)
            OP_START: begin
              wraps_left_nxt = cmd.cmd_data;
              state_nxt      = RUN;
            end
            OP_LOAD: begin
              modulus_nxt = cmd.cmd_data;
              count_nxt   = '0;
            end
            OP_CLEAR: count_nxt = '0;
            OP_STOP:  ;
          endcase
        end
      end

      RUN: begin
        advance = tick;
        if (accept) begin
          case (cmd.cmd_op)
            OP_STOP: begin
              state_nxt = HOLD;
              advance   = 1'b0;
            end
            OP_CLEAR: begin
              count_nxt = '0;
              advance   = 1'b0;
            end
            OP_LOAD:  cmd_err_nxt = 1'b1;
            OP_START: ;
          endcase
        end
        if (advance) begin
          count_nxt = at_top ? '0 : count + N'(1);
          if (at_top) begin
            wrap_nxt = 1'b1;
            // wraps_left of 0 means free-running: never decrement, never finish
            if (wraps_left == N'(1)) begin
              state_nxt      = DONE;
              done_nxt       = 1'b1;
              wraps_left_nxt = '0;
            end else if (wraps_left > N'(1)) begin
              wraps_left_nxt = wraps_left - N'(1);
            end
          end
        end
      end

      HOLD: begin
        if (accept) begin
          case (cmd.cmd_op)
            OP_START: state_nxt = RUN;
            OP_CLEAR: begin
              count_nxt      = '0;
              wraps_left_nxt = '0;
              state_nxt      = IDLE;
            end
            OP_LOAD:  cmd_err_nxt = 1'b1;
            OP_STOP:  ;
          endcase
        end
      end

      DONE: begin
        count_nxt = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      modulus    <= N'(K);
      wraps_left <= '0;
      wrap       <= 1'b0;
      done       <= 1'b0;
      cmd_err    <= 1'b0;
    end else begin
      state      <= state_nxt;
      count      <= count_nxt;
      modulus    <= modulus_nxt;
      wraps_left <= wraps_left_nxt;
      wrap       <= wrap_nxt;
      done       <= done_nxt;
      cmd_err    <= cmd_err_nxt;
    end
  end

endmodule

// File: tb/tb_modulo_counter_ctrl.sv
// tb/tb_modulo_counter_ctrl.sv - directed scoreboard bench for modulo_counter_ctrl
module tb_modulo_counter_ctrl;

  localparam logic [1:0] OP_START = 2'b00;
  localparam logic [1:0] OP_STOP  = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;
  localparam logic [1:0] OP_LOAD  = 2'b11;

  typedef struct packed {
    logic [7:0] cnt;
    logic       wrp;
    logic       dn;
    logic       bsy;
    logic       rdy;
    logic       err;
  } obs_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       tick  = 1'b0;
  logic [7:0] count, modulus;
  logic       wrap, done, busy, cmd_err;

  int errors = 0;
  int checks = 0;

  obs_t  exp_q[$];
  string tag_q[$];

  modulo_counter_ctrl_if #(.N(8)) cmd_if ();

  modulo_counter_ctrl #(.N(8), .K(10)) dut (
    .clock   (clock),
    .reset   (reset),
    .cmd     (cmd_if),
    .tick    (tick),
    .count   (count),
    .modulus (modulus),
    .wrap    (wrap),
    .done    (done),
    .busy    (busy),
    .cmd_err (cmd_err)
  );

  always #5 clock = ~clock;

  task automatic step(input string tag, input logic v, input logic [1:0] op, input logic [7:0] d,
                      input logic t, input logic [7:0] c, input logic w, input logic dn,
                      input logic b, input logic r, input logic e);
    obs_t x, o;
    string tg;
    cmd_if.cmd_valid = v;
    cmd_if.cmd_op    = op;
    cmd_if.cmd_data  = d;
    tick             = t;
    exp_q.push_back({c, w, dn, b, r, e});
    tag_q.push_back(tag);
    @(posedge clock);
    #1;
    x  = exp_q.pop_front();
    tg = tag_q.pop_front();
    o  = {count, wrap, done, busy, cmd_if.cmd_ready, cmd_err};
    checks++;
    assert (o === x) else begin
      errors++;
      $error("FAIL %s: observed cnt=%0d wrap=%b done=%b busy=%b rdy=%b err=%b, expected cnt=%0d wrap=%b done=%b busy=%b rdy=%b err=%b",
             tg, o.cnt, o.wrp, o.dn, o.bsy, o.rdy, o.err, x.cnt, x.wrp, x.dn, x.bsy, x.rdy, x.err);
    end
  endtask

  task automatic chk_mod(input string tag, input logic [7:0] m);
    checks++;
    assert (modulus === m) else begin
      errors++;
      $error("FAIL %s: modulus observed=%0d expected=%0d", tag, modulus, m);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = OP_START;
    cmd_if.cmd_data  = 8'd0;

    // reset state
    reset = 1'b1;
    step("reset", 0, OP_START, 0, 0, 0, 0, 0, 0, 1, 0);
    chk_mod("reset_mod", 8'd10);
    reset = 1'b0;

    // modulus 5, two wraps, tick every cycle
    step("load5", 1, OP_LOAD, 5, 1, 0, 0, 0, 0, 1, 0);
    chk_mod("load5_mod", 8'd5);
    step("start_r2", 1, OP_START, 2, 1, 0, 0, 0, 1, 1, 0);
    for (int i = 1; i <= 10; i++)
      step("mod5_run", 0, OP_START, 0, 1, 8'(i % 5), (i % 5) == 0, i == 10, i != 10, i != 10, 0);
    step("mod5_idle", 0, OP_START, 0, 1, 0, 0, 0, 0, 1, 0);

    // modulus 0 gives the full 256-count range
    step("load0", 1, OP_LOAD, 0, 0, 0, 0, 0, 0, 1, 0);
    step("start_r1", 1, OP_START, 1, 0, 0, 0, 0, 1, 1, 0);
    for (int i = 1; i <= 256; i++)
      step("mod0_run", 0, OP_START, 0, 1, 8'(i), i == 256, i == 256, i != 256, i != 256, 0);
    step("mod0_idle", 0, OP_START, 0, 0, 0, 0, 0, 0, 1, 0);

    // modulus 1 wraps on every tick
    step("load1", 1, OP_LOAD, 1, 0, 0, 0, 0, 0, 1, 0);
    step("start_r3", 1, OP_START, 3, 0, 0, 0, 0, 1, 1, 0);
    for (int i = 1; i <= 3; i++)
      step("mod1_run", 0, OP_START, 0, 1, 0, 1, i == 3, i != 3, i != 3, 0);
    step("mod1_idle", 0, OP_START, 0, 1, 0, 0, 0, 0, 1, 0);

    // pause, illegal LOAD in HOLD, resume, clear
    step("load10", 1, OP_LOAD, 10, 0, 0, 0, 0, 0, 1, 0);
    step("start_r0", 1, OP_START, 0, 0, 0, 0, 0, 1, 1, 0);
    for (int i = 1; i <= 3; i++)
      step("pause_run", 0, OP_START, 0, 1, 8'(i), 0, 0, 1, 1, 0);
    step("stop_tick", 1, OP_STOP, 0, 1, 3, 0, 0, 1, 1, 0);
    step("hold_tick", 0, OP_START, 0, 1, 3, 0, 0, 1, 1, 0);
    step("hold_load", 1, OP_LOAD, 3, 0, 3, 0, 0, 1, 1, 1);
    chk_mod("hold_load_mod", 8'd10);
    step("resume", 1, OP_START, 9, 0, 3, 0, 0, 1, 1, 0);
    step("resume_t4", 0, OP_START, 0, 1, 4, 0, 0, 1, 1, 0);
    step("resume_t5", 0, OP_START, 0, 1, 5, 0, 0, 1, 1, 0);
    step("stop2", 1, OP_STOP, 0, 0, 5, 0, 0, 1, 1, 0);
    step("clear_hold", 1, OP_CLEAR, 0, 0, 0, 0, 0, 0, 1, 0);

    // illegal LOAD in RUN, CLEAR beats tick at the top, free-running wrap
    step("start_free", 1, OP_START, 0, 0, 0, 0, 0, 1, 1, 0);
    for (int i = 1; i <= 3; i++)
      step("free_run", 0, OP_START, 0, 1, 8'(i), 0, 0, 1, 1, 0);
    step("run_load7", 1, OP_LOAD, 7, 0, 3, 0, 0, 1, 1, 1);
    step("err_drop", 0, OP_START, 0, 0, 3, 0, 0, 1, 1, 0);
    chk_mod("run_load_mod", 8'd10);
    for (int i = 4; i <= 9; i++)
      step("free_run2", 0, OP_START, 0, 1, 8'(i), 0, 0, 1, 1, 0);
    step("clear_tick", 1, OP_CLEAR, 0, 1, 0, 0, 0, 1, 1, 0);
    for (int i = 1; i <= 10; i++)
      step("r0_wrap", 0, OP_START, 0, 1, 8'(i % 10), i == 10, 0, 1, 1, 0);
    step("stop3", 1, OP_STOP, 0, 0, 0, 0, 0, 1, 1, 0);
    step("clear3", 1, OP_CLEAR, 0, 0, 0, 0, 0, 0, 1, 0);

    // mid-run reset drops the in-flight command and restores modulus
    step("load12", 1, OP_LOAD, 12, 1, 0, 0, 0, 0, 1, 0);
    chk_mod("load12_mod", 8'd12);
    step("start_r4", 1, OP_START, 4, 0, 0, 0, 0, 1, 1, 0);
    for (int i = 1; i <= 6; i++)
      step("pre_reset", 0, OP_START, 0, 1, 8'(i), 0, 0, 1, 1, 0);
    reset = 1'b1;
    step("mid_reset", 1, OP_START, 4, 1, 0, 0, 0, 0, 1, 0);
    reset = 1'b0;
    chk_mod("mid_reset_mod", 8'd10);
    for (int i = 1; i <= 20; i++)
      step("idle_ticks", 0, OP_START, 0, 1, 0, 0, 0, 0, 1, 0);

    // command held across DONE is taken only once IDLE is reached
    step("load2", 1, OP_LOAD, 2, 0, 0, 0, 0, 0, 1, 0);
    step("start_bp", 1, OP_START, 1, 0, 0, 0, 0, 1, 1, 0);
    step("bp_t1", 0, OP_START, 0, 1, 1, 0, 0, 1, 1, 0);
    step("bp_done", 1, OP_START, 1, 1, 0, 1, 1, 0, 0, 0);
    step("bp_in_done", 1, OP_START, 1, 1, 0, 0, 0, 0, 1, 0);
    step("bp_accept", 1, OP_START, 1, 1, 0, 0, 0, 1, 1, 0);
    step("bp_t2", 0, OP_START, 0, 1, 1, 0, 0, 1, 1, 0);
    step("bp_done2", 0, OP_START, 0, 1, 0, 1, 1, 0, 0, 0);
    step("bp_idle", 0, OP_START, 0, 1, 0, 0, 0, 0, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
